// File: rtl/data_mem_arbiter_pkg.sv
// Shared state encoding, default widths and port index constants for the data memory arbiter.
package data_mem_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way combinational tie-break: turns the two requests and the last grant into a one-hot grant.
module data_mem_arbiter_rr_arb2
    import data_mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
)
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // A lone requester wins; a tie goes to port 0 in fixed mode, otherwise to the port not served last.
    always_comb begin
        grant = 2'b00;
        if (req0 && req1) begin
            if ((FIXED_PRIO != 0) || (last_grant == PORT1)) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single negedge-sampled data memory port between the CPU (port 0) and the DMA (port 1),
// one registered access every two clocks, with read data returned on a one-cycle rvalid pulse.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIXED_PRIO = 0
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              last_grant_q;
    logic              last_grant_d;
    logic [1:0]        grant;
    logic              winner;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              mem_we_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              gnt0_d;
    logic              gnt1_d;
    logic              rvalid0_d;
    logic              rvalid1_d;
    logic [DATA_W-1:0] rdata_d;
    logic              busy_d;

    data_mem_arbiter_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arb2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign winner = grant[1] ? PORT1 : PORT0;

    // Next-state and next-output logic; during ACCESS the port in flight is last_grant and a read is !mem_we.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata_d      = rdata;
        busy_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d      = ACCESS;
                    last_grant_d = winner;
                    mem_addr_d   = (winner == PORT1) ? addr1  : addr0;
                    mem_we_d     = (winner == PORT1) ? we1    : we0;
                    mem_wdata_d  = (winner == PORT1) ? wdata1 : wdata0;
                    gnt0_d       = (winner == PORT0);
                    gnt1_d       = (winner == PORT1);
                    busy_d       = 1'b1;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (!mem_we) begin
                    rdata_d   = mem_rdata;
                    rvalid0_d = (last_grant_q == PORT0);
                    rvalid1_d = (last_grant_q == PORT1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops mem_we at once so no write lands while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= PORT1;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            rvalid0      <= 1'b0;
            rvalid1      <= 1'b0;
            rdata        <= '0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_addr     <= mem_addr_d;
            mem_we       <= mem_we_d;
            mem_wdata    <= mem_wdata_d;
            gnt0         <= gnt0_d;
            gnt1         <= gnt1_d;
            rvalid0      <= rvalid0_d;
            rvalid1      <= rvalid1_d;
            rdata        <= rdata_d;
            busy         <= busy_d;
        end
    end

endmodule
